window_buffer: RTL and testbench
================================

WINDOW_BUFFER -- requirements
Module: window_buffer

Interface
REQ-001 Parameter IMG_W, 640, image width in pixels.
REQ-002 Parameter IMG_H, 480, image height in pixels.
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 pix_in  input  8  raster-order input pixel.
REQ-006 pix_valid  input  1  pix_in is valid this cycle.
REQ-007 pix_ready  output  1  block accepts pix_in this cycle; a transfer occurs when pix_valid && pix_ready.
REQ-008 win_row  output  10  row of the window's centre pixel.
REQ-009 win_col  output  10  column of the window's centre pixel.
REQ-010 win_pixels  output  64  the 8 neighbours packed {top_left, top, top_right, mid_left, mid_right, bot_left, bot, bot_right}, MSB first.
REQ-011 win_start  output  1  one-cycle pulse: window valid, filter may begin.
REQ-012 win_done  input  1  filter idle/result ready (high when not busy).
REQ-013 frame_done  output  1  one-cycle pulse after the last window of a frame completes.

Function
REQ-014 The block SHALL feed the Sobel filter one 3x3 window per image pixel, for all IMG_W*IMG_H centres, in raster order.
REQ-015 The block SHALL track the input position (in_row, in_col) and the centre position (win_row, win_col), each wrapping the column at IMG_W-1 and the row at IMG_H-1.
REQ-016 Raster index k = row*IMG_W + col; accepting input index k SHALL emit the window for centre index k-(IMG_W+1) when that index is >= 0.
REQ-017 Storage: two line buffers of IMG_W x 8 bits (previous row, row before that), plus a 3x3 register window that shifts one column per accepted or injected pixel.
REQ-018 Neighbours outside the image SHALL read as 8'h00: top row when win_row==0; bottom row when win_row==IMG_H-1; left column when win_col==0; right column when win_col==IMG_W-1.
REQ-019 The FSM SHALL have the states IDLE, ACCEPT, ISSUE, HOLD.
  - IDLE: entered after reset; moves to ACCEPT on the next cycle.
  - ACCEPT: pix_ready=1 unless flushing; on a transfer or an injected pixel, shift; go to ISSUE if a centre is emitted, else stay.
  - ISSUE: win_start=1 for exactly one cycle; go to HOLD.
  - HOLD: win_row, win_col and win_pixels are held stable; win_done is ignored in the first HOLD cycle; afterwards, win_done==1 ends HOLD.
  - On leaving HOLD: go to IDLE and pulse frame_done if the centre was (IMG_H-1, IMG_W-1); otherwise go to ACCEPT.
REQ-020 Flush: after input (IMG_H-1, IMG_W-1) is accepted, a flushing flag SHALL be set; pix_ready=0; ACCEPT then injects a zero pixel each visit, without waiting for pix_valid, until the last centre is emitted (IMG_W+1 injections).
REQ-021 pix_ready SHALL be 0 in IDLE, ISSUE and HOLD, and 0 while flushing.
REQ-022 Throughput: at most one window per 3 cycles (ACCEPT, ISSUE, >=1 HOLD); back-pressure is only via pix_ready.
REQ-023 Pixel data presented while pix_ready=0 SHALL be ignored.
REQ-024 Latency: win_start SHALL rise one cycle after the transfer (or injection) that completes the window.
REQ-025 The first IMG_W+1 transfers of a frame SHALL produce no win_start.
REQ-026 Simultaneous win_done and a new pix_valid in HOLD: pix_valid SHALL be ignored until the next ACCEPT cycle.

Reset
REQ-027 reset SHALL force state=IDLE, flushing=0, all counters to 0, and the window registers to 0.
REQ-028 Outputs under reset: pix_ready=0, win_start=0, frame_done=0, win_row=0, win_col=0, win_pixels=0.
REQ-029 Line-buffer contents need not be cleared; the REQ-018 masking guarantees that stale data never appears in a window.
REQ-030 Reset mid-frame SHALL abandon the frame; the next accepted pixel is (0,0).

Structure
REQ-031 A shared package SHALL hold IMG_W/IMG_H defaults, the FSM state encoding, and the window packing-order constants; the Sobel filter also uses these.
REQ-032 One sub-module, line_buffer (IMG_W x 8, one synchronous write and one read port per cycle), SHALL be instantiated twice.

Verification (IMG_W=4, IMG_H=3, pixel value = raster index + 1, i.e. 1..12)
REQ-033 Frame with pix_valid held high -> the 6th transfer (value 6) produces the first win_start with centre (0,0), win_pixels=0x0000000002000506.
REQ-034 Same frame -> window for centre (1,1), win_pixels=0x010203050709_0A0B (0x01020305_07090A0B); exactly 12 win_start pulses per frame; frame_done pulses once, after the 12th HOLD completes.
REQ-035 Flush -> after the 12th transfer, pix_ready stays 0 while 5 zero injections emit centres (1,3) through (2,3); centre (2,3) gives win_pixels=0x0708000B00000000.
REQ-036 Filter stall: win_done held low for 10 cycles in HOLD -> win_* outputs stable, pix_ready=0, no extra win_start.
REQ-037 Edge-centre filter: win_done already high in the first HOLD cycle -> it is ignored; HOLD exits on the second cycle.
REQ-038 reset asserted after 7 transfers -> all outputs return to 0; the next frame reproduces REQ-033 exactly.

Source files
------------

// File: rtl/window_buffer_pkg.sv
// Shared definitions for the 3x3 window buffer and the Sobel filter that consumes it:
// image size defaults, FSM encoding, window packing order and the packing helper.
package window_buffer_pkg;

    localparam int IMG_W_DEFAULT = 640;
    localparam int IMG_H_DEFAULT = 480;
    localparam int PIX_W         = 8;
    localparam int COORD_W       = 10;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCEPT = 2'd1;
    localparam logic [1:0] ST_ISSUE  = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    // Byte slot of each neighbour inside win_pixels; slot 7 is the most significant byte.
    localparam int SLOT_TL = 7;
    localparam int SLOT_T  = 6;
    localparam int SLOT_TR = 5;
    localparam int SLOT_ML = 4;
    localparam int SLOT_MR = 3;
    localparam int SLOT_BL = 2;
    localparam int SLOT_B  = 1;
    localparam int SLOT_BR = 0;

    // 3x3 window indexed [row][col]; row 0 is the top row, col 0 the left column.
    typedef logic [2:0][2:0][PIX_W-1:0] window_t;

    // Zero the neighbours that fall outside the image, then pack the eight of them.
    function automatic logic [8*PIX_W-1:0] pack_window(
        input window_t w,
        input logic    mask_top,
        input logic    mask_bot,
        input logic    mask_left,
        input logic    mask_right
    );
        window_t             m;
        logic [8*PIX_W-1:0]  px;
        m = w;
        if (mask_top)   m[0] = '0;
        if (mask_bot)   m[2] = '0;
        for (int r = 0; r < 3; r++) begin
            if (mask_left)  m[r][0] = '0;
            if (mask_right) m[r][2] = '0;
        end
        px = '0;
        px[SLOT_TL*PIX_W +: PIX_W] = m[0][0];
        px[SLOT_T *PIX_W +: PIX_W] = m[0][1];
        px[SLOT_TR*PIX_W +: PIX_W] = m[0][2];
        px[SLOT_ML*PIX_W +: PIX_W] = m[1][0];
        px[SLOT_MR*PIX_W +: PIX_W] = m[1][2];
        px[SLOT_BL*PIX_W +: PIX_W] = m[2][0];
        px[SLOT_B *PIX_W +: PIX_W] = m[2][1];
        px[SLOT_BR*PIX_W +: PIX_W] = m[2][2];
        return px;
    endfunction

endpackage

// File: rtl/window_buffer_line_buffer.sv
// One image row of pixel storage: synchronous write, combinational read at the same column.
// A read and a write to the same column in one cycle returns the previous row's pixel.
module line_buffer
    import window_buffer_pkg::*;
#(
    parameter int DEPTH  = IMG_W_DEFAULT,
    parameter int ADDR_W = $clog2(IMG_W_DEFAULT)
)(
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [PIX_W-1:0]  wr_data,
    output logic [PIX_W-1:0]  rd_data
);

    logic [PIX_W-1:0] mem [DEPTH];

    // Store the incoming pixel at the current column.
    // NOTE: the storage array has no reset; border masking keeps stale rows out of every window,
    // and leaving it unreset lets it map onto RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

    assign rd_data = mem[addr];

endmodule

// File: rtl/window_buffer.sv
// Raster-order pixel stream to 3x3 windows, one window per image pixel, handed to a
// Sobel filter with a start/done handshake. Two line buffers feed a shifting 3x3 window;
// after the last input pixel, zero pixels are injected to flush the final centres.
module window_buffer
    import window_buffer_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEFAULT,
    parameter int IMG_H = IMG_H_DEFAULT
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [PIX_W-1:0]     pix_in,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    output logic [COORD_W-1:0]   win_row,
    output logic [COORD_W-1:0]   win_col,
    output logic [8*PIX_W-1:0]   win_pixels,
    output logic                 win_start,
    input  logic                 win_done,
    output logic                 frame_done
);

    localparam int                 ADDR_W   = $clog2(IMG_W);
    localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(IMG_W - 1);
    localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(IMG_H - 1);

    logic [1:0]          state;
    logic                hold_first;
    logic                flushing;
    logic [COORD_W-1:0]  in_row, in_col;
    logic [COORD_W-1:0]  cen_row, cen_col;
    window_t             win_q, win_next;
    logic [PIX_W-1:0]    lb0_rd, lb1_rd, shift_pix;
    logic                xfer, shift, emit, hold_exit, last_centre, last_input;

    assign pix_ready   = (state == ST_ACCEPT) && !flushing;
    assign win_start   = (state == ST_ISSUE);
    assign xfer        = pix_ready && pix_valid;
    // While flushing, every ACCEPT visit injects a zero pixel without waiting for pix_valid.
    assign shift       = (state == ST_ACCEPT) && (flushing || pix_valid);
    assign shift_pix   = flushing ? '0 : pix_in;
    // A centre is emitted once IMG_W+1 pixels of the frame are in, i.e. from input (1,1) on.
    assign emit        = flushing || (in_row >= COORD_W'(2)) ||
                         ((in_row == COORD_W'(1)) && (in_col != '0));
    assign last_input  = (in_row == LAST_ROW) && (in_col == LAST_COL);
    assign last_centre = (win_row == LAST_ROW) && (win_col == LAST_COL);
    assign hold_exit   = (state == ST_HOLD) && !hold_first && win_done;

    // Line buffer 0 holds the previous row, line buffer 1 the row before that.
    line_buffer #(.DEPTH(IMG_W), .ADDR_W(ADDR_W)) u_lb0 (
        .clk     (clk),
        .wr_en   (shift),
        .addr    (in_col[ADDR_W-1:0]),
        .wr_data (shift_pix),
        .rd_data (lb0_rd)
    );

    line_buffer #(.DEPTH(IMG_W), .ADDR_W(ADDR_W)) u_lb1 (
        .clk     (clk),
        .wr_en   (shift),
        .addr    (in_col[ADDR_W-1:0]),
        .wr_data (lb0_rd),
        .rd_data (lb1_rd)
    );

    // Window contents after shifting in the column {row-2, row-1, new pixel}.
    // NOTE: the whole result is assigned first, so no path leaves win_next unassigned (no latch).
    always_comb begin
        win_next = win_q;
        for (int r = 0; r < 3; r++) begin
            win_next[r][0] = win_q[r][1];
            win_next[r][1] = win_q[r][2];
        end
        win_next[0][2] = lb1_rd;
        win_next[1][2] = lb0_rd;
        win_next[2][2] = shift_pix;
    end

    // Handshake FSM: accept/inject, one-cycle start pulse, hold until the filter is done.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            hold_first <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE:   state <= ST_ACCEPT;
                ST_ACCEPT: if (shift && emit) state <= ST_ISSUE;
                ST_ISSUE: begin
                    state      <= ST_HOLD;
                    hold_first <= 1'b1;
                end
                ST_HOLD: begin
                    if (hold_first) begin
                        hold_first <= 1'b0;
                    end else if (win_done) begin
                        state      <= last_centre ? ST_IDLE : ST_ACCEPT;
                        frame_done <= last_centre;
                    end
                end
                default:   state <= ST_IDLE;
            endcase
        end
    end

    // Input position and flush flag; both restart when the frame's last window completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_row   <= '0;
            in_col   <= '0;
            flushing <= 1'b0;
        end else if (hold_exit && last_centre) begin
            in_row   <= '0;
            in_col   <= '0;
            flushing <= 1'b0;
        end else if (shift) begin
            if (xfer && last_input) begin
                flushing <= 1'b1;
            end
            if (in_col == LAST_COL) begin
                in_col <= '0;
                in_row <= (in_row == LAST_ROW) ? '0 : in_row + COORD_W'(1);
            end else begin
                in_col <= in_col + COORD_W'(1);
            end
        end
    end

    // Shift the window; on emission latch the masked window and its centre for the filter.
    always_ff @(posedge clk) begin
        if (reset) begin
            win_q      <= '0;
            cen_row    <= '0;
            cen_col    <= '0;
            win_row    <= '0;
            win_col    <= '0;
            win_pixels <= '0;
        end else if (shift) begin
            win_q <= win_next;
            if (emit) begin
                win_row    <= cen_row;
                win_col    <= cen_col;
                win_pixels <= pack_window(win_next,
                                          cen_row == '0, cen_row == LAST_ROW,
                                          cen_col == '0, cen_col == LAST_COL);
                if (cen_col == LAST_COL) begin
                    cen_col <= '0;
                    cen_row <= (cen_row == LAST_ROW) ? '0 : cen_row + COORD_W'(1);
                end else begin
                    cen_col <= cen_col + COORD_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_window_buffer.sv
// Bench for window_buffer on a 4x3 image: randomized pixels, valid gaps and filter stalls,
// checked against a neighbourhood model computed directly from the image array.
module tb_window_buffer;

    localparam int W    = 4;
    localparam int H    = 3;
    localparam int NPIX = W * H;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  pix_in = 8'h00;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [9:0]  win_row, win_col;
    logic [63:0] win_pixels;
    logic        win_start;
    logic        win_done = 1'b1;
    logic        frame_done;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [7:0]  img [NPIX];
    logic [63:0] got_pix [NPIX];
    int          got_count;
    int          flush_starts;

    window_buffer #(.IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .reset      (reset),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .win_row    (win_row),
        .win_col    (win_col),
        .win_pixels (win_pixels),
        .win_start  (win_start),
        .win_done   (win_done),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Eight neighbours of (r,c) from the image, zero outside, packed TL first.
    function automatic logic [63:0] model_window(input int r, input int c);
        logic [63:0] res;
        logic [7:0]  v;
        int          rr, cc;
        res = '0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if (dr != 0 || dc != 0) begin
                    rr = r + dr;
                    cc = c + dc;
                    v = (rr >= 0 && rr < H && cc >= 0 && cc < W) ? img[rr*W + cc] : 8'h00;
                    res = {res[55:0], v};
                end
            end
        end
        return res;
    endfunction

    task automatic check_outputs_zero(input string tag);
        n_checks++;
        if (pix_ready !== 1'b0) $display("FAIL %s pix_ready: got %b expected 0", tag, pix_ready);
        else n_pass++;
        n_checks++;
        if (win_start !== 1'b0) $display("FAIL %s win_start: got %b expected 0", tag, win_start);
        else n_pass++;
        n_checks++;
        if (frame_done !== 1'b0) $display("FAIL %s frame_done: got %b expected 0", tag, frame_done);
        else n_pass++;
        n_checks++;
        if (win_row !== 10'd0) $display("FAIL %s win_row: got %0d expected 0", tag, win_row);
        else n_pass++;
        n_checks++;
        if (win_col !== 10'd0) $display("FAIL %s win_col: got %0d expected 0", tag, win_col);
        else n_pass++;
        n_checks++;
        if (win_pixels !== 64'd0) $display("FAIL %s win_pixels: got %h expected 0", tag, win_pixels);
        else n_pass++;
    endtask

    // Drive one frame (or the first stop_after transfers) and check every window handshake.
    task automatic run_frame(input bit counting, input int valid_pct, input int stall_min,
                             input int stall_max, input int stop_after);
        int          sent, starts, released, since, stall, rel_at, cyc, er, ec;
        bit          pending, prev_xfer, xfer_now, finished;
        logic [9:0]  cap_row, cap_col;
        logic [63:0] cap_pix, exp_pix;
        for (int i = 0; i < NPIX; i++) img[i] = counting ? 8'(i + 1) : 8'($urandom);
        sent = 0; starts = 0; released = 0; since = 0; stall = 0; rel_at = 0; cyc = 0;
        pending = 0; prev_xfer = 0; finished = 0;
        cap_row = '0; cap_col = '0; cap_pix = '0;
        got_count = 0; flush_starts = 0;
        while (!finished) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc > 3000) begin
                n_checks++;
                $display("FAIL frame_timeout: got %0d windows released, expected %0d", released, NPIX);
                break;
            end
            xfer_now = 0;
            if (pending) begin
                since++;
                if (since == rel_at) begin
                    pending = 0;
                    released++;
                    if (released == NPIX) begin
                        n_checks++;
                        if (frame_done !== 1'b1) $display("FAIL frame_done_pulse: got %b expected 1", frame_done);
                        else n_pass++;
                        n_checks++;
                        if (pix_ready !== 1'b0) $display("FAIL ready_after_frame: got %b expected 0", pix_ready);
                        else n_pass++;
                        finished = 1;
                    end else begin
                        n_checks++;
                        if (pix_ready !== (sent < NPIX)) $display("FAIL ready_after_hold: got %b expected %b", pix_ready, sent < NPIX);
                        else n_pass++;
                        n_checks++;
                        if (frame_done !== 1'b0) $display("FAIL early_frame_done: got %b expected 0", frame_done);
                        else n_pass++;
                    end
                end else begin
                    n_checks++;
                    if ({win_start, pix_ready, frame_done} !== 3'b000)
                        $display("FAIL hold_controls: got start/ready/done %b expected 000", {win_start, pix_ready, frame_done});
                    else n_pass++;
                    n_checks++;
                    if ({win_row, win_col, win_pixels} !== {cap_row, cap_col, cap_pix})
                        $display("FAIL hold_stable: got (%0d,%0d) %h expected (%0d,%0d) %h", win_row, win_col, win_pixels, cap_row, cap_col, cap_pix);
                    else n_pass++;
                end
            end else if (win_start === 1'b1) begin
                n_checks++;
                if (starts >= NPIX) begin
                    $display("FAIL extra_win_start: got start %0d expected at most %0d", starts + 1, NPIX);
                end else begin
                    n_pass++;
                    er = starts / W;
                    ec = starts % W;
                    exp_pix = model_window(er, ec);
                    n_checks++;
                    if (win_row !== 10'(er) || win_col !== 10'(ec))
                        $display("FAIL centre %0d: got (%0d,%0d) expected (%0d,%0d)", starts, win_row, win_col, er, ec);
                    else n_pass++;
                    n_checks++;
                    if (win_pixels !== exp_pix)
                        $display("FAIL win_pixels centre %0d: got %h expected %h", starts, win_pixels, exp_pix);
                    else n_pass++;
                    n_checks++;
                    if (starts + W + 1 < NPIX) begin
                        if (!(prev_xfer && sent == starts + W + 2))
                            $display("FAIL latency centre %0d: got transfers %0d (prev %b) expected %0d (prev 1)", starts, sent, prev_xfer, starts + W + 2);
                        else n_pass++;
                    end else begin
                        if (sent != NPIX) $display("FAIL flush_latency centre %0d: got transfers %0d expected %0d", starts, sent, NPIX);
                        else n_pass++;
                    end
                    n_checks++;
                    if (pix_ready !== 1'b0) $display("FAIL issue_ready: got %b expected 0", pix_ready);
                    else n_pass++;
                    if (!prev_xfer && sent == NPIX) flush_starts++;
                    got_pix[starts] = win_pixels;
                    got_count++;
                end
                starts++;
                pending = 1;
                since = 0;
                stall = $urandom_range(stall_min, stall_max);
                rel_at = ((1 + stall) > 2 ? (1 + stall) : 2) + 1;
                cap_row = win_row; cap_col = win_col; cap_pix = win_pixels;
            end else begin
                n_checks++;
                if (frame_done !== 1'b0) $display("FAIL stray_frame_done: got %b expected 0", frame_done);
                else n_pass++;
                if (sent == NPIX) begin
                    n_checks++;
                    if (pix_ready !== 1'b0) $display("FAIL flush_ready: got %b expected 0", pix_ready);
                    else n_pass++;
                end
            end
            if (finished) break;
            win_done = pending ? (since >= 1 + stall) : 1'b1;
            if (pix_ready === 1'b1) begin
                pix_valid = ($urandom_range(0, 99) < valid_pct);
                pix_in = (pix_valid && sent < NPIX) ? img[sent] : 8'($urandom);
                if (pix_valid) begin
                    sent++;
                    xfer_now = 1;
                end
            end else begin
                pix_valid = 1'($urandom_range(0, 1));
                pix_in = 8'($urandom);
            end
            prev_xfer = xfer_now;
            if (stop_after >= 0 && sent == stop_after && xfer_now) break;
        end
        if (stop_after < 0) begin
            pix_valid = 1'b0;
            win_done = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        pix_valid = 1'b1;
        pix_in = 8'hAA;
        win_done = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        reset = 1'b0;
        pix_valid = 1'b0;
    endtask

    task automatic test_fixed_frame();
        run_frame(1'b1, 100, 0, 0, -1);
        n_checks++;
        if (got_count != NPIX) $display("FAIL window_count: got %0d expected %0d", got_count, NPIX);
        else n_pass++;
        n_checks++;
        if (got_pix[0] !== 64'h0000000002000506) $display("FAIL first_window: got %h expected 0000000002000506", got_pix[0]);
        else n_pass++;
        n_checks++;
        if (got_pix[5] !== 64'h0102030507090A0B) $display("FAIL centre_1_1: got %h expected 0102030507090a0b", got_pix[5]);
        else n_pass++;
        n_checks++;
        if (got_pix[11] !== 64'h0708000B00000000) $display("FAIL centre_2_3: got %h expected 0708000b00000000", got_pix[11]);
        else n_pass++;
        n_checks++;
        if (flush_starts != W + 1) $display("FAIL flush_windows: got %0d expected %0d", flush_starts, W + 1);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        run_frame(1'b0, 100, 0, 0, -1);
        run_frame(1'b0, 100, 0, 0, -1);
        @(posedge clk); #1;
        n_checks++;
        if (frame_done !== 1'b0) $display("FAIL frame_done_width: got %b expected 0", frame_done);
        else n_pass++;
        n_checks++;
        if (pix_ready !== 1'b1) $display("FAIL next_frame_ready: got %b expected 1", pix_ready);
        else n_pass++;
        // Finish the frame just opened so later tests start at a frame boundary.
        run_frame(1'b0, 100, 0, 0, -1);
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 3; f++) run_frame(1'b0, 60, 0, 4, -1);
    endtask

    task automatic test_stall();
        run_frame(1'b0, 100, 10, 10, -1);
    endtask

    task automatic test_mid_reset();
        run_frame(1'b1, 100, 0, 0, 7);
        @(posedge clk); #1;
        reset = 1'b1;
        pix_valid = 1'b0;
        win_done = 1'b1;
        @(posedge clk); #1;
        check_outputs_zero("mid_reset");
        reset = 1'b0;
        run_frame(1'b1, 100, 0, 0, -1);
        n_checks++;
        if (got_pix[0] !== 64'h0000000002000506) $display("FAIL first_window_after_reset: got %h expected 0000000002000506", got_pix[0]);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_fixed_frame();
        test_back_to_back();
        test_random_frames();
        test_stall();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
